// File: rtl/lsm_seq.sv
// lsm_seq: load/store-multiple sequencer.
// Takes one LDM/STM descriptor and walks the register list lowest index first.
// It drives one register-file access and one data-memory handshake per word.
// Base writeback, when requested, happens in a final one-cycle WB state.
// Optional build macro LSM_PC_LOAD_EN: an LDM that includes R15 loads the PC
// through pc_load_o/pc_data_o. Without the macro, R15 is removed from LDM lists.
module lsm_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        load_i,
    input  logic [15:0] reglist_i,
    input  logic [31:0] base_i,
    input  logic [3:0]  base_reg_i,
    input  logic        up_i,
    input  logic        pre_i,
    input  logic        wb_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  rf_ra_o,
    input  logic [31:0] rf_rd_i,
    output logic        rf_we_o,
    output logic [3:0]  rf_wa_o,
    output logic [31:0] rf_wd_o,
    output logic        pc_load_o,
    output logic [31:0] pc_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_WB} state_t;

    state_t      state_q;
    logic [15:0] list_q;
    logic [31:0] base_q;
    logic [3:0]  base_reg_q;
    logic        load_q;
    logic        up_q;
    logic        pre_q;
    logic        wb_q;
    logic        base_in_list_q;
    logic [4:0]  n_q;
    logic [31:0] addr_q;
    logic [31:0] wbval_q;
    logic        busy_q;
    logic        done_q;
    logic        req_q;
    logic        we_q;

    logic [15:0] latch_list;
    logic [4:0]  setup_n;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [31:0] wb_value;
    logic [3:0]  cur_reg;
    logic [15:0] list_next;
    logic        xfer_ack;
    logic        ld_ack;
    logic        pc_sel;
    logic        wb_fire;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

`ifdef LSM_PC_LOAD_EN
    assign latch_list = reglist_i;
    assign pc_sel     = (cur_reg == 4'd15);
`else
    // R15 never reaches the transfer loop of an LDM in this build.
    assign latch_list = load_i ? {1'b0, reglist_i[14:0]} : reglist_i;
    assign pc_sel     = 1'b0;
`endif

    assign setup_n   = popcount16(list_q);
    assign four_n    = {25'd0, setup_n, 2'b00};
    assign wb_value  = up_q ? (base_q + four_n) : (base_q - four_n);
    assign cur_reg   = lowest_set(list_q);
    assign list_next = list_q & ~(16'd1 << cur_reg);
    assign xfer_ack  = req_q && mem_ack_i;
    assign ld_ack    = xfer_ack && load_q;
    // A loaded base register keeps its loaded value, so writeback is suppressed.
    assign wb_fire   = wb_q && (base_reg_q != 4'd15) && (n_q != 5'd0) &&
                       !(load_q && base_in_list_q);

    // First transfer address for the four addressing modes (IA/IB/DA/DB).
    always_comb begin
        unique case ({up_q, pre_q})
            2'b10:   start_addr = base_q;
            2'b11:   start_addr = base_q + 32'd4;
            2'b00:   start_addr = base_q - four_n + 32'd4;
            default: start_addr = base_q - four_n;
        endcase
    end

    // Sequencer FSM; holds the descriptor and registers the handshake strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            list_q         <= '0;
            base_q         <= '0;
            base_reg_q     <= '0;
            load_q         <= 1'b0;
            up_q           <= 1'b0;
            pre_q          <= 1'b0;
            wb_q           <= 1'b0;
            base_in_list_q <= 1'b0;
            n_q            <= '0;
            addr_q         <= '0;
            wbval_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        list_q         <= latch_list;
                        base_q         <= base_i;
                        base_reg_q     <= base_reg_i;
                        load_q         <= load_i;
                        up_q           <= up_i;
                        pre_q          <= pre_i;
                        wb_q           <= wb_i;
                        base_in_list_q <= latch_list[base_reg_i];
                        busy_q         <= 1'b1;
                        state_q        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    n_q     <= setup_n;
                    addr_q  <= start_addr;
                    wbval_q <= wb_value;
                    if (setup_n == 5'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_WB;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= !load_q;
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ack_i) begin
                        list_q <= list_next;
                        addr_q <= addr_q + 32'd4;
                        if (list_next == 16'd0) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_WB;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_req_o  = req_q;
    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;

    // Register-file and PC side: store data read, load data and base writeback.
    always_comb begin
        rf_ra_o     = '0;
        mem_wdata_o = '0;
        rf_we_o     = 1'b0;
        rf_wa_o     = '0;
        rf_wd_o     = '0;
        pc_load_o   = 1'b0;
        pc_data_o   = '0;
        if (req_q && !load_q) begin
            rf_ra_o     = cur_reg;
            mem_wdata_o = rf_rd_i;
        end
        if (ld_ack && pc_sel) begin
            pc_load_o = 1'b1;
            pc_data_o = {mem_rdata_i[31:2], 2'b00};
        end else if (ld_ack) begin
            rf_we_o = 1'b1;
            rf_wa_o = cur_reg;
            rf_wd_o = mem_rdata_i;
        end
        if (state_q == S_WB && wb_fire) begin
            rf_we_o = 1'b1;
            rf_wa_o = base_reg_q;
            rf_wd_o = wbval_q;
        end
    end

endmodule
